cp2_xfer_ctrl: RTL and testbench
================================

// Module: cp2_xfer_ctrl
// PURPOSE
//  Sequences every coprocessor-2 transaction issued by the MEM stage: action (AS), CPU->CP2 write (TS/TDS) and CP2->CPU read (FS/FDS).
//  Waits out the CP2 busy lines, drives one-cycle strobes, and collects read data or a CP2 exception.
//  Bounds each wait with a timeout and reports a completion pulse to ctrl; ctrl stalls the pipe while busy=1.
//  Sits between mem_stage/ctrl and the cp2_*_0 port group of cpu.
// PARAMETERS
//  TIMEOUT   255   max cycles spent in WAIT_RDY or WAIT_DATA before forced completion
//  EXC_W     4     width of cp2_exccode / exc_code (= `CP2EXECCODEBUS width)
//  TO_CODE   4'hF  exc_code reported on timeout
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      synchronous reset, active high
//  req_valid     in   1      MEM stage requests a CP2 transaction
//  req_type      in   2      0=ACT, 1=TO (write), 2=FROM (read), 3=reserved
//  req_data      in   32     write data for TO
//  flush         in   1      pipeline flush from ctrl
//  req_ready     out  1      1 only in IDLE; transfer when req_valid&req_ready
//  busy          out  1      state != IDLE
//  done          out  1      one-cycle completion pulse
//  rd_data       out  32     FROM result, valid with done
//  exc           out  1      done carries CP2 exception or timeout
//  exc_code      out  EXC_W  cp2_exccode or TO_CODE, valid with done
//  cp2_as_0      out  1      action strobe
//  cp2_ts_0      out  1      to-strobe
//  cp2_tds_0     out  1      to-data-valid, coincident with cp2_ts_0
//  cp2_tdata_0   out  32     latched req_data
//  cp2_fs_0      out  1      from-strobe
//  cp2_abusy_0/cp2_tbusy_0/cp2_fbusy_0  in  1 each  CP2 busy per transaction type
//  cp2_fds_0     in   1      CP2 read data valid
//  cp2_fdata_0   in   32     CP2 read data
//  cp2_excs_0    in   1      exception status valid
//  cp2_exc_0     in   1      exception flag (sampled when cp2_excs_0=1)
//  cp2_exccode_0 in   EXC_W  exception code
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; counter, discard flag cleared. Reset mid-transaction abandons it; strobes low from next cycle.
//  FSM (Moore; strobes decode registered state): IDLE, WAIT_RDY, STROBE, WAIT_DATA, DONE.
//  IDLE: on req_valid latch type/data, clear counter -> WAIT_RDY. req_type=3 -> DONE with exc=1, exc_code=0, no strobe.
//  WAIT_RDY: busy line of latched type low -> STROBE; else count++. flush here -> IDLE, no strobe, no done.
//  STROBE: one cycle; ACT: cp2_as_0=1; TO: cp2_ts_0=cp2_tds_0=1; FROM: cp2_fs_0=1. ACT/TO -> DONE; FROM -> WAIT_DATA (counter cleared).
//  WAIT_DATA: cp2_fds_0=1 -> capture cp2_fdata_0 into rd_data -> DONE; else count++.
//  Exception: cp2_excs_0&cp2_exc_0 in STROBE or WAIT_DATA -> capture exccode, exc=1 -> DONE (takes priority over fds same cycle).
//  Timeout: counter==TIMEOUT-1 with no exit condition -> DONE, exc=1, exc_code=TO_CODE. Counter saturates, 8-bit min ($clog2(TIMEOUT+1)).
//  DONE: done=1 for one cycle, rd_data/exc/exc_code stable that cycle -> IDLE. New request accepted the cycle after DONE.
//  flush in STROBE/WAIT_DATA/DONE: bus transaction completes normally, sets discard; done suppressed (0) in DONE; discard cleared in IDLE.
//  Min latency (busy low): accept@0, WAIT_RDY@1, STROBE@2, done@3 (ACT/TO); FROM with fds@3 -> done@4.
//  cp2_tdata_0 holds latched data from accept until next accept; rd_data/exc_code hold until next DONE.
// STRUCTURE
//  Shared header (bus.vh): CP2 req_type encodings, state encodings, TO_CODE default.
//  One sub-module: cp2_timeout_cnt (clear/enable/saturating counter, expired flag).
// TESTING
//  ACT, abusy=0 -> cp2_as_0 high exactly cycle 2, done@3, exc=0.
//  TO data 32'hDEADBEEF, tbusy high 5 cycles -> ts/tds one cycle after tbusy falls with tdata=DEADBEEF, done next.
//  FROM, fds after 3 cycles with fdata 32'h12345678 -> done, rd_data=12345678.
//  FROM, excs=exc=1 code 4'h3 in WAIT_DATA -> done, exc=1, exc_code=3, no fds needed.
//  fbusy stuck 1, TIMEOUT=8 -> done after 8 WAIT_RDY cycles, exc=1, exc_code=F, no strobe.
//  flush in WAIT_RDY -> IDLE, no strobe/done; flush after STROBE -> bus completes, done=0; rst in WAIT_DATA -> IDLE.

Source files
------------

// File: rtl/cp2_xfer_ctrl_pkg.sv
// Shared definitions for the coprocessor-2 transfer controller:
// request encodings, FSM states and the default timeout exception code.
package cp2_xfer_ctrl_pkg;

   typedef enum logic [1:0] {
      REQ_ACT  = 2'd0,
      REQ_TO   = 2'd1,
      REQ_FROM = 2'd2,
      REQ_RSVD = 2'd3
   } req_type_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_RDY  = 3'd1,
      ST_STROBE    = 3'd2,
      ST_WAIT_DATA = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam logic [3:0] TO_CODE_DEF = 4'hF;

   // Counter must hold TIMEOUT and is never narrower than a byte.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w > 8) ? w : 8;
   endfunction

endpackage

// File: rtl/cp2_timeout_cnt.sv
// Saturating wait counter; o_expired flags the last permitted wait cycle.
module cp2_timeout_cnt #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count enabled wait cycles, holding at LIMIT so expiry stays asserted.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/cp2_xfer_ctrl.sv
// Sequences MEM-stage coprocessor-2 transactions (action, write, read):
// waits out CP2 busy, issues one-cycle strobes, collects data/exceptions.
module cp2_xfer_ctrl
   import cp2_xfer_ctrl_pkg::*;
#(
   parameter int               TIMEOUT = 255,
   parameter int               EXC_W   = 4,
   parameter logic [EXC_W-1:0] TO_CODE = EXC_W'(TO_CODE_DEF)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req_valid,
   input  logic [1:0]       i_req_type,
   input  logic [31:0]      i_req_data,
   input  logic             i_flush,
   output logic             o_req_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [31:0]      o_rd_data,
   output logic             o_exc,
   output logic [EXC_W-1:0] o_exc_code,
   output logic             o_cp2_as_0,
   output logic             o_cp2_ts_0,
   output logic             o_cp2_tds_0,
   output logic [31:0]      o_cp2_tdata_0,
   output logic             o_cp2_fs_0,
   input  logic             i_cp2_abusy_0,
   input  logic             i_cp2_tbusy_0,
   input  logic             i_cp2_fbusy_0,
   input  logic             i_cp2_fds_0,
   input  logic [31:0]      i_cp2_fdata_0,
   input  logic             i_cp2_excs_0,
   input  logic             i_cp2_exc_0,
   input  logic [EXC_W-1:0] i_cp2_exccode_0
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   state_e           r_state;
   state_e           w_next_state;
   req_type_e        r_type;
   logic [31:0]      r_tdata;
   logic [31:0]      r_rd_data;
   logic             r_exc;
   logic             r_discard;
   logic [EXC_W-1:0] r_exc_code;
   logic [EXC_W-1:0] w_exc_code_nxt;
   logic             w_busy_sel;
   logic             w_cp2_exc;
   logic             w_expired;
   logic             w_cnt_clr;
   logic             w_cnt_en;
   logic             w_exc_set;
   logic             w_cap_rd;
   logic             w_accept;
   logic             w_done;

   assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
   assign w_cp2_exc = i_cp2_excs_0 && i_cp2_exc_0;

   // Busy line belonging to the latched transaction type.
   always_comb begin
      case (r_type)
         REQ_ACT:  w_busy_sel = i_cp2_abusy_0;
         REQ_TO:   w_busy_sel = i_cp2_tbusy_0;
         REQ_FROM: w_busy_sel = i_cp2_fbusy_0;
         default:  w_busy_sel = 1'b0;
      endcase
   end

   cp2_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_cnt_clr),
      .i_en      (w_cnt_en),
      .o_expired (w_expired)
   );

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state plus datapath/counter controls.
   always_comb begin
      w_next_state   = r_state;
      w_cnt_clr      = 1'b0;
      w_cnt_en       = 1'b0;
      w_exc_set      = 1'b0;
      w_exc_code_nxt = r_exc_code;
      w_cap_rd       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!i_req_valid) begin
               w_next_state = ST_IDLE;
            end else if (i_req_type == REQ_RSVD) begin
               w_next_state   = ST_DONE;
               w_exc_set      = 1'b1;
               w_exc_code_nxt = '0;
            end else begin
               w_next_state = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (i_flush) begin
               w_next_state = ST_IDLE;
            end else if (!w_busy_sel) begin
               w_next_state = ST_STROBE;
            end else if (w_expired) begin
               w_next_state   = ST_DONE;
               w_exc_set      = 1'b1;
               w_exc_code_nxt = TO_CODE;
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         ST_STROBE: begin
            w_cnt_clr = 1'b1;
            if (w_cp2_exc) begin
               w_next_state   = ST_DONE;
               w_exc_set      = 1'b1;
               w_exc_code_nxt = i_cp2_exccode_0;
            end else if (r_type == REQ_FROM) begin
               w_next_state = ST_WAIT_DATA;
            end else begin
               w_next_state = ST_DONE;
            end
         end
         ST_WAIT_DATA: begin
            // Exception outranks data arriving in the same cycle.
            if (w_cp2_exc) begin
               w_next_state   = ST_DONE;
               w_exc_set      = 1'b1;
               w_exc_code_nxt = i_cp2_exccode_0;
            end else if (i_cp2_fds_0) begin
               w_next_state = ST_DONE;
               w_cap_rd     = 1'b1;
            end else if (w_expired) begin
               w_next_state   = ST_DONE;
               w_exc_set      = 1'b1;
               w_exc_code_nxt = TO_CODE;
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Latched request, captured results and the flush-discard flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_type     <= REQ_ACT;
         r_tdata    <= 32'h0000_0000;
         r_rd_data  <= 32'h0000_0000;
         r_exc      <= 1'b0;
         r_exc_code <= '0;
         r_discard  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_type  <= req_type_e'(i_req_type);
            r_tdata <= i_req_data;
         end
         if (w_cap_rd) begin
            r_rd_data <= i_cp2_fdata_0;
         end
         if (w_exc_set) begin
            r_exc_code <= w_exc_code_nxt;
         end
         if (r_state == ST_IDLE) begin
            r_exc <= w_exc_set;
         end else if (w_exc_set) begin
            r_exc <= 1'b1;
         end
         if (r_state == ST_IDLE) begin
            r_discard <= 1'b0;
         end else if (i_flush && ((r_state == ST_STROBE) || (r_state == ST_WAIT_DATA) ||
                                  (r_state == ST_DONE))) begin
            r_discard <= 1'b1;
         end
      end
   end

   assign w_done = (r_state == ST_DONE) && !r_discard && !i_flush;

   assign o_req_ready   = (r_state == ST_IDLE);
   assign o_busy        = (r_state != ST_IDLE);
   assign o_done        = w_done;
   assign o_exc         = w_done && r_exc;
   assign o_exc_code    = r_exc_code;
   assign o_rd_data     = r_rd_data;
   assign o_cp2_tdata_0 = r_tdata;
   assign o_cp2_as_0    = (r_state == ST_STROBE) && (r_type == REQ_ACT);
   assign o_cp2_ts_0    = (r_state == ST_STROBE) && (r_type == REQ_TO);
   assign o_cp2_tds_0   = (r_state == ST_STROBE) && (r_type == REQ_TO);
   assign o_cp2_fs_0    = (r_state == ST_STROBE) && (r_type == REQ_FROM);

endmodule

// File: tb/tb_cp2_xfer_ctrl.sv
// Directed plus randomized transactions against a cycle-outcome model of the
// coprocessor-2 transfer controller.
module tb_cp2_xfer_ctrl;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_type;
   logic [31:0] req_data;
   logic        flush;
   logic        req_ready, busy, done, exc;
   logic [31:0] rd_data;
   logic [3:0]  exc_code;
   logic        as0, ts0, tds0, fs0;
   logic [31:0] tdata0;
   logic        abusy, tbusy, fbusy, fds, excs, exc_in;
   logic [31:0] fdata;
   logic [3:0]  exccode;

   int n_vec = 0;
   int n_err = 0;

   cp2_xfer_ctrl #(.TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_type(req_type),
      .i_req_data(req_data), .i_flush(flush), .o_req_ready(req_ready), .o_busy(busy),
      .o_done(done), .o_rd_data(rd_data), .o_exc(exc), .o_exc_code(exc_code),
      .o_cp2_as_0(as0), .o_cp2_ts_0(ts0), .o_cp2_tds_0(tds0), .o_cp2_tdata_0(tdata0),
      .o_cp2_fs_0(fs0), .i_cp2_abusy_0(abusy), .i_cp2_tbusy_0(tbusy),
      .i_cp2_fbusy_0(fbusy), .i_cp2_fds_0(fds), .i_cp2_fdata_0(fdata),
      .i_cp2_excs_0(excs), .i_cp2_exc_0(exc_in), .i_cp2_exccode_0(exccode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_type = 2'd0; req_data = 32'h0; flush = 1'b0;
      abusy = 1'b0; tbusy = 1'b0; fbusy = 1'b0; fds = 1'b0; fdata = 32'h0;
      excs = 1'b0; exc_in = 1'b0; exccode = 4'h0;
   endtask

   // ty: 0 ACT, 1 TO, 2 FROM, 3 reserved. bcyc: cycles the type's busy stays
   // high after accept. dly: WAIT_DATA cycle index of fds. ee: cycle after the
   // strobe carrying an exception (0 = strobe cycle, <0 none). fl: flush cycle.
   task automatic run_txn(input int ty, input logic [31:0] data, input int bcyc,
                          input int dly, input int ee, input logic [3:0] icode,
                          input int fl);
      int s, done_c, end_c, wr_last, ev_exc, ev_fds, ev_to;
      int n_str, str_c, n_done, done_obs, n_tds_bad;
      bit aborted, has_strobe, exp_exc, exp_rdv, dis, busy_on;
      logic [3:0]  exp_code, d_code;
      logic [31:0] exp_rd, fds_val, str_tdata, d_rd;
      logic [2:0]  str_kind, exp_kind;
      logic        d_exc;

      fds_val = $urandom;
      exp_exc = 1'b0; exp_code = 4'h0; exp_rdv = 1'b0; exp_rd = 32'h0;
      has_strobe = 1'b0; aborted = 1'b0; s = -100; done_c = -1;
      if (ty == 3) begin
         done_c = 1; exp_exc = 1'b1; exp_code = 4'h0;
      end else begin
         wr_last = (bcyc >= TMO) ? TMO : bcyc + 1;
         if (fl >= 1 && fl <= wr_last) begin
            aborted = 1'b1;
         end else if (bcyc >= TMO) begin
            done_c = TMO + 1; exp_exc = 1'b1; exp_code = 4'hF;
         end else begin
            has_strobe = 1'b1;
            s = bcyc + 2;
            if (ee == 0) begin
               done_c = s + 1; exp_exc = 1'b1; exp_code = icode;
            end else if (ty != 2) begin
               done_c = s + 1;
            end else begin
               ev_exc = (ee > 0) ? s + ee : 1 << 20;
               ev_fds = s + 1 + dly;
               ev_to  = s + TMO;
               if (ev_exc <= ev_fds && ev_exc <= ev_to) begin
                  done_c = ev_exc + 1; exp_exc = 1'b1; exp_code = icode;
               end else if (ev_fds <= ev_to) begin
                  done_c = ev_fds + 1; exp_rdv = 1'b1; exp_rd = fds_val;
               end else begin
                  done_c = ev_to + 1; exp_exc = 1'b1; exp_code = 4'hF;
               end
            end
         end
      end
      dis   = !aborted && fl >= 1 && fl <= done_c;
      end_c = aborted ? fl + 1 : done_c + 1;
      exp_kind = (ty == 0) ? 3'b100 : (ty == 1) ? 3'b010 : 3'b001;

      n_str = 0; str_c = -1; n_done = 0; done_obs = -1; n_tds_bad = 0;
      str_kind = 3'b000; str_tdata = 32'h0; d_rd = 32'h0; d_exc = 1'b0; d_code = 4'h0;
      for (int k = 0; k <= end_c + 2; k++) begin
         @(posedge clk); #1;
         req_valid = (k == 0);
         req_type  = ty[1:0];
         req_data  = (k == 0) ? data : $urandom;
         busy_on   = (k >= 1 && k <= bcyc);
         abusy = (ty == 0) ? busy_on : 1'($urandom);
         tbusy = (ty == 1) ? busy_on : 1'($urandom);
         fbusy = (ty == 2) ? busy_on : 1'($urandom);
         fds   = has_strobe && ty == 2 && (k == s + 1 + dly);
         fdata = fds ? fds_val : $urandom;
         if (has_strobe && ee >= 0 && k == s + ee) begin
            excs = 1'b1; exc_in = 1'b1; exccode = icode;
         end else if ($urandom_range(0, 1) == 1) begin
            excs = 1'b1; exc_in = 1'b0; exccode = 4'($urandom);
         end else begin
            excs = 1'b0; exc_in = 1'($urandom); exccode = 4'($urandom);
         end
         flush = (k == fl);
         @(negedge clk);
         if (as0 || ts0 || fs0) begin
            n_str++; str_c = k; str_kind = {as0, ts0, fs0}; str_tdata = tdata0;
         end
         if (tds0 !== ts0) n_tds_bad++;
         if (done) begin
            n_done++; done_obs = k; d_rd = rd_data; d_exc = exc; d_code = exc_code;
         end
      end
      idle_inputs();

      chk("strobe_count", 64'(n_str), 64'(has_strobe));
      if (has_strobe) begin
         chk("strobe_cycle", 64'(str_c), 64'(s));
         chk("strobe_kind", 64'(str_kind), 64'(exp_kind));
         if (ty == 1) chk("strobe_tdata", 64'(str_tdata), 64'(data));
      end
      chk("tds_eq_ts", 64'(n_tds_bad), 64'd0);
      chk("done_count", 64'(n_done), (aborted || dis) ? 64'd0 : 64'd1);
      if (!aborted && !dis) begin
         chk("done_cycle", 64'(done_obs), 64'(done_c));
         chk("done_exc", 64'(d_exc), 64'(exp_exc));
         if (exp_exc) chk("done_exc_code", 64'(d_code), 64'(exp_code));
         if (exp_rdv) begin
            chk("done_rd_data", 64'(d_rd), 64'(exp_rd));
            chk("rd_data_hold", 64'(rd_data), 64'(exp_rd));
         end
      end
      chk("idle_after", 64'(busy), 64'd0);
      chk("tdata_hold", 64'(tdata0), 64'(data));
   endtask

   initial begin
      int ty, b, d, e, f, nf, nd;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_strobes", 64'({as0, ts0, tds0, fs0}), 64'd0);
      chk("rst_tdata", 64'(tdata0), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_exc", 64'({exc, exc_code}), 64'd0);

      run_txn(0, 32'h0BAD_F00D, 0, 0, -1, 4'h0, -1);         // ACT, no busy
      run_txn(1, 32'hDEAD_BEEF, 5, 0, -1, 4'h0, -1);         // TO, busy 5 cycles
      run_txn(2, 32'h0000_0001, 0, 3, -1, 4'h0, -1);         // FROM, fds after 3
      run_txn(2, 32'h0000_0002, 0, 20, 2, 4'h3, -1);         // FROM, exception 3
      run_txn(2, 32'h0000_0003, 30, 0, -1, 4'h0, -1);        // fbusy stuck: timeout
      run_txn(0, 32'h0000_0004, 4, 0, -1, 4'h0, 3);          // flush in WAIT_RDY
      run_txn(2, 32'h0000_0005, 0, 2, -1, 4'h0, 3);          // flush after strobe
      run_txn(3, 32'h0000_0006, 0, 0, -1, 4'h0, -1);         // reserved type
      run_txn(2, 32'h0000_0007, 1, 20, -1, 4'h0, -1);        // WAIT_DATA timeout
      run_txn(2, 32'h0000_0008, 0, 1, 2, 4'h9, -1);          // exc same cycle as fds
      run_txn(1, 32'h0000_0009, 7, 0, -1, 4'h0, -1);         // busy drops at last slot

      // Reset in WAIT_DATA abandons the read.
      nf = 0; nd = 0;
      for (int k = 0; k <= 8; k++) begin
         @(posedge clk); #1;
         req_valid = (k == 0); req_type = 2'd2; req_data = 32'h5555_AAAA;
         rst = (k == 4);
         @(negedge clk);
         if (k >= 5 && fs0) nf++;
         if (done) nd++;
         if (k == 5) chk("rst_mid_busy", 64'(busy), 64'd0);
      end
      idle_inputs();
      chk("rst_mid_no_strobe", 64'(nf), 64'd0);
      chk("rst_mid_no_done", 64'(nd), 64'd0);

      for (int i = 0; i < 200; i++) begin
         ty = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         b  = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 6);
         d  = $urandom_range(0, 10);
         e  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
         f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : -1;
         run_txn(ty, $urandom, b, d, e, 4'($urandom), f);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
